regfile_wb_arbiter: RTL and testbench

- Shares the single regfile write port between two writeback sources.
  - Port A: in-order pipeline WB stage. Fixed priority, never stalled.
  - Port B: a long-latency unit (mul/div, load miss) using a valid/ready handshake.
- Holds one B result in an internal buffer until the write port is free.
- Keeps a 32-bit pending-write scoreboard so decode can stall on RAW/WAW against long-latency destinations.
- Sits between the WB stage, the long-latency unit and regfile (we/wa/din).

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/wb_scoreboard.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_pkg;

    localparam int XLEN         = 32;
    localparam int NREG         = 32;
    localparam int REG_IDX_W    = $clog2(NREG);
    localparam int STARVE_LIMIT = 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // x0 is hardwired, so a zero index never names a real write.
    function automatic logic idx_nonzero(input reg_idx_t idx);
        return idx != {REG_IDX_W{1'b0}};
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, three lookups.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    input  logic [REG_IDX_W-1:0] q_rd,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 busy_rd
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Per-register update; a same-cycle set beats the drain clear, bit 0 stays clear.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            if (i == 0) begin
                busy_nxt_s[i] = 1'b0;
            end else if (set_en && (set_idx == reg_idx_t'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (clr_en && (clr_idx == reg_idx_t'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_rs1 = busy_r[q_rs1];
    assign busy_rs2 = busy_r[q_rs2];
    assign busy_rd  = busy_r[q_rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the WB stage (A) and a buffered long-latency source (B).
// Optional starvation stall request enabled by defining REGFILE_WB_ARB_STARVE_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_we,
    input  logic [REG_IDX_W-1:0] a_wa,
    input  logic [XLEN-1:0]      a_din,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [REG_IDX_W-1:0] b_wa,
    input  logic [XLEN-1:0]      b_din,
    input  logic                 sb_set,
    input  logic [REG_IDX_W-1:0] sb_rd,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    input  logic [REG_IDX_W-1:0] q_rd,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 busy_rd,
    output logic                 stall_req,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_wa,
    output logic [XLEN-1:0]      rf_din
);

    buf_state_t state_r;
    buf_state_t state_nxt_s;
    reg_idx_t   hold_wa_r;
    word_t      hold_din_r;

    logic hold_v_s;
    logic a_act_s;
    logic drain_s;
    logic b_accept_s;

    assign hold_v_s   = (state_r == BUF_FULL);
    assign a_act_s    = a_we && idx_nonzero(a_wa);
    assign drain_s    = hold_v_s && !a_act_s;
    // b_wa==0 is still handshaken away, it just never occupies the buffer.
    assign b_accept_s = (state_r == BUF_EMPTY) && b_valid && idx_nonzero(b_wa);
    assign b_ready    = !hold_v_s;

    // Buffer next-state: fill from B when empty, drain whenever A leaves the port free.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BUF_EMPTY: begin
                if (b_accept_s) begin
                    state_nxt_s = BUF_FULL;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (drain_s) begin
                    state_nxt_s = BUF_EMPTY;
                end else begin
                    state_nxt_s = BUF_FULL;
                end
            end
            default: state_nxt_s = BUF_EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Buffer payload, captured only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_wa_r  <= {REG_IDX_W{1'b0}};
            hold_din_r <= {XLEN{1'b0}};
        end else if (b_accept_s) begin
            hold_wa_r  <= b_wa;
            hold_din_r <= b_din;
        end else begin
            hold_wa_r  <= hold_wa_r;
            hold_din_r <= hold_din_r;
        end
    end

    // Write-port mux: A has fixed priority, the buffer fills idle cycles.
    always_comb begin
        rf_we  = 1'b0;
        rf_wa  = {REG_IDX_W{1'b0}};
        rf_din = {XLEN{1'b0}};
        if (a_act_s) begin
            rf_we  = 1'b1;
            rf_wa  = a_wa;
            rf_din = a_din;
        end else if (hold_v_s) begin
            rf_we  = 1'b1;
            rf_wa  = hold_wa_r;
            rf_din = hold_din_r;
        end else begin
            rf_we  = 1'b0;
            rf_wa  = {REG_IDX_W{1'b0}};
            rf_din = {XLEN{1'b0}};
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_idx  (sb_rd),
        .clr_en   (drain_s),
        .clr_idx  (hold_wa_r),
        .q_rs1    (q_rs1),
        .q_rs2    (q_rs2),
        .q_rd     (q_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

`ifdef REGFILE_WB_ARB_STARVE_EN
    logic [7:0] starve_cnt_r;

    // Counts cycles the buffered entry loses to A; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 8'd0;
        end else if (drain_s) begin
            starve_cnt_r <= 8'd0;
        end else if (hold_v_s && a_act_s && (starve_cnt_r != 8'hFF)) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign stall_req = (starve_cnt_r >= 8'(STARVE_LIMIT));
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic vs. a reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_we, b_valid, sb_set;
    logic [4:0]  a_wa, b_wa, sb_rd, q_rs1, q_rs2, q_rd;
    logic [31:0] a_din, b_din;
    logic        b_ready, busy_rs1, busy_rs2, busy_rd, stall_req, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_din;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a one-entry holding slot plus a set of pending registers.
    bit          m_full;
    logic [4:0]  m_wa;
    logic [31:0] m_din;
    bit [31:0]   m_busy;
    int          m_starve;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_wa(a_wa), .a_din(a_din),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_din(b_din),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
        .stall_req(stall_req),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_din(rf_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_full   = 1'b0;
        m_wa     = 5'd0;
        m_din    = 32'd0;
        m_busy   = 32'd0;
        m_starve = 0;
    endtask

    task automatic idle();
        a_we = 1'b0; a_wa = 5'd0; a_din = 32'd0;
        b_valid = 1'b0; b_wa = 5'd0; b_din = 32'd0;
        sb_set = 1'b0; sb_rd = 5'd0;
    endtask

    // Compare all outputs against the model for the current inputs, then advance one clock.
    task automatic cyc();
        bit          a_act, drain, e_we, e_stall;
        logic [31:0] e_wa, e_din;
        #1;
        if (!rst_n) model_reset();
        a_act = a_we && (a_wa != 5'd0);
        e_we  = a_act || m_full;
        e_wa  = a_act ? {27'd0, a_wa} : (m_full ? {27'd0, m_wa} : 32'd0);
        e_din = a_act ? a_din : (m_full ? m_din : 32'd0);
`ifdef REGFILE_WB_ARB_STARVE_EN
        e_stall = (m_starve >= 8);
`else
        e_stall = 1'b0;
`endif
        check("rf_we",     {31'd0, rf_we},     {31'd0, e_we});
        check("rf_wa",     {27'd0, rf_wa},     e_wa);
        check("rf_din",    rf_din,             e_din);
        check("b_ready",   {31'd0, b_ready},   {31'd0, !m_full});
        check("busy_rs1",  {31'd0, busy_rs1},  {31'd0, m_busy[q_rs1]});
        check("busy_rs2",  {31'd0, busy_rs2},  {31'd0, m_busy[q_rs2]});
        check("busy_rd",   {31'd0, busy_rd},   {31'd0, m_busy[q_rd]});
        check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
        @(posedge clk);
        if (rst_n) begin
            drain = m_full && !a_act;
            if (drain) begin
                m_busy[m_wa] = 1'b0;
                m_starve = 0;
            end else if (m_full && a_act) begin
                m_starve++;
            end
            if (sb_set && sb_rd != 5'd0) m_busy[sb_rd] = 1'b1;
            if (drain) begin
                m_full = 1'b0;
            end else if (!m_full && b_valid && b_wa != 5'd0) begin
                m_full = 1'b1;
                m_wa   = b_wa;
                m_din  = b_din;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        idle();
        q_rs1 = 5'd9; q_rs2 = 5'd10; q_rd = 5'd0;
        rst_n = 1'b0;
        @(negedge clk);

        // Reset holds everything quiet even with requests present.
        b_valid = 1'b1; b_wa = 5'd5; b_din = 32'h1234_5678; sb_set = 1'b1; sb_rd = 5'd9;
        #1;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_ready", {31'd0, b_ready}, 32'd1);
        check("rst_busy", {31'd0, busy_rs1}, 32'd0);
        cyc(); cyc();
        idle();
        rst_n = 1'b1;
        cyc(); cyc();

        // Idle port: B result written the next cycle, b_ready low for that cycle only.
        b_valid = 1'b1; b_wa = 5'd5; b_din = 32'hDEAD_BEEF;
        cyc();
        idle();
        #1;
        check("idle_we", {31'd0, rf_we}, 32'd1);
        check("idle_wa", {27'd0, rf_wa}, 32'd5);
        check("idle_din", rf_din, 32'hDEAD_BEEF);
        check("idle_ready", {31'd0, b_ready}, 32'd0);
        cyc();
        #1 check("idle_ready_back", {31'd0, b_ready}, 32'd1);
        cyc();

        // Conflict: A owns the port for three cycles, the buffer waits.
        b_valid = 1'b1; b_wa = 5'd7; b_din = 32'h11;
        cyc();
        idle();
        a_we = 1'b1; a_wa = 5'd3; a_din = 32'h22;
        repeat (3) begin
            #1;
            check("conf_wa", {27'd0, rf_wa}, 32'd3);
            check("conf_ready", {31'd0, b_ready}, 32'd0);
            cyc();
        end
        a_we = 1'b0;
        #1;
        check("conf_drain_wa", {27'd0, rf_wa}, 32'd7);
        check("conf_drain_din", rf_din, 32'h11);
        cyc(); cyc();

        // Scoreboard set, set-beats-clear, normal clear, x0 never set.
        sb_set = 1'b1; sb_rd = 5'd9;
        #1 check("sb_no_bypass", {31'd0, busy_rs1}, 32'd0);
        cyc();
        sb_set = 1'b0;
        #1 check("sb_set", {31'd0, busy_rs1}, 32'd1);
        b_valid = 1'b1; b_wa = 5'd9; b_din = 32'h99;
        cyc();
        b_valid = 1'b0; sb_set = 1'b1; sb_rd = 5'd9;
        cyc();
        sb_set = 1'b0;
        #1 check("sb_set_wins", {31'd0, busy_rs1}, 32'd1);
        b_valid = 1'b1; b_wa = 5'd9; b_din = 32'h9A;
        cyc();
        b_valid = 1'b0;
        #1 check("sb_before_clr", {31'd0, busy_rs1}, 32'd1);
        cyc();
        #1 check("sb_cleared", {31'd0, busy_rs1}, 32'd0);
        sb_set = 1'b1; sb_rd = 5'd0; q_rd = 5'd0;
        cyc();
        sb_set = 1'b0;
        #1 check("sb_x0", {31'd0, busy_rd}, 32'd0);
        cyc();

        // x0 handling on both sources.
        b_valid = 1'b1; b_wa = 5'd4; b_din = 32'h44;
        cyc();
        idle();
        a_we = 1'b1; a_wa = 5'd0; a_din = 32'h55;
        #1;
        check("x0_a_wa", {27'd0, rf_wa}, 32'd4);
        check("x0_a_din", rf_din, 32'h44);
        cyc();
        idle();
        b_valid = 1'b1; b_wa = 5'd0; b_din = 32'h66;
        cyc();
        idle();
        #1;
        check("x0_b_we", {31'd0, rf_we}, 32'd0);
        check("x0_b_ready", {31'd0, b_ready}, 32'd1);
        cyc();

        // Starvation: buffer loses to A for eight cycles.
        b_valid = 1'b1; b_wa = 5'd6; b_din = 32'h66;
        cyc();
        idle();
        a_we = 1'b1; a_wa = 5'd2; a_din = 32'h2;
        repeat (8) cyc();
`ifdef REGFILE_WB_ARB_STARVE_EN
        #1 check("starve_req", {31'd0, stall_req}, 32'd1);
`else
        #1 check("starve_off", {31'd0, stall_req}, 32'd0);
`endif
        a_we = 1'b0;
        #1 check("starve_drain_wa", {27'd0, rf_wa}, 32'd6);
        cyc();
        #1 check("starve_clear", {31'd0, stall_req}, 32'd0);
        cyc();

        // Mid-operation reset drops the buffer and pending bits.
        b_valid = 1'b1; b_wa = 5'd10; b_din = 32'hAA; sb_set = 1'b1; sb_rd = 5'd10;
        cyc();
        idle();
        a_we = 1'b1; a_wa = 5'd1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, b_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy_rs2}, 32'd0);
        cyc();
        rst_n = 1'b1;
        idle();
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            a_we    = ($urandom_range(0, 1) == 1);
            if (m_starve >= 8) a_we = 1'b0;
            a_wa    = 5'($urandom_range(0, 31));
            a_din   = $urandom;
            b_valid = ($urandom_range(0, 2) == 0);
            b_wa    = 5'($urandom_range(0, 31));
            b_din   = $urandom;
            sb_set  = ($urandom_range(0, 3) == 0);
            sb_rd   = 5'($urandom_range(0, 31));
            q_rs1   = 5'($urandom_range(0, 31));
            q_rs2   = 5'($urandom_range(0, 31));
            q_rd    = 5'($urandom_range(0, 31));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
